// File: rtl/load_store_unit.sv
// Load/store unit: one request in flight, word and sub-word loads/stores against
// a word-addressed memory, with read-modify-write for byte/half stores.
module load_store_unit #(
  parameter int DATA_WIDTH   = 32,
  parameter int MEMORY_DEPTH = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic                  resp_error,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic [31:0]           Address,
  output logic [DATA_WIDTH-1:0] WriteData,
  input  logic [DATA_WIDTH-1:0] ReadData
);

  typedef enum logic [2:0] {IDLE, LOAD, STORE, RMW_READ, RMW_WRITE, RESP} state_t;

  localparam logic [31:0] DEPTH_W = 32'(MEMORY_DEPTH);

  state_t                state_q, state_d;
  logic                  req_ready_q, req_ready_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_error_q, resp_error_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic                  mem_read_q, mem_read_d;
  logic                  mem_write_q, mem_write_d;
  logic [31:0]           address_q, address_d;
  logic [DATA_WIDTH-1:0] write_data_q, write_data_d;
  logic                  write_q, write_d;
  logic [1:0]            size_q, size_d;
  logic                  unsigned_q, unsigned_d;
  logic [31:0]           addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  accept;
  logic                  req_err;

  function automatic logic [DATA_WIDTH-1:0] load_lane(
    input logic [DATA_WIDTH-1:0] word,
    input logic [1:0]            size,
    input logic [1:0]            lane,
    input logic                  uns
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = word[8*lane +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'd0:    load_lane = {{24{b[7] & ~uns}}, b};
      2'd1:    load_lane = {{16{h[15] & ~uns}}, h};
      default: load_lane = word;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] merge_lane(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_data,
    input logic [1:0]            size,
    input logic [1:0]            lane
  );
    merge_lane = old_word;
    if (size == 2'd0) merge_lane[8*lane +: 8] = new_data[7:0];
    else              merge_lane[16*lane[1] +: 16] = new_data[15:0];
  endfunction

  assign accept  = req_valid && req_ready_q;
  assign req_err = (req_size == 2'd3)
                || (req_size == 2'd1 && req_addr[0])
                || (req_size == 2'd2 && req_addr[1:0] != 2'b00)
                || ({2'b00, req_addr[31:2]} >= DEPTH_W);

  always_comb begin
    state_d      = state_q;
    req_ready_d  = 1'b0;
    resp_valid_d = 1'b0;
    resp_error_d = 1'b0;
    resp_rdata_d = '0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    address_d    = '0;
    write_data_d = '0;
    write_d      = write_q;
    size_d       = size_q;
    unsigned_d   = unsigned_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (accept) begin
          write_d     = req_write;
          size_d      = req_size;
          unsigned_d  = req_unsigned;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          req_ready_d = 1'b0;
          if (req_err) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
          end else if (!req_write) begin
            state_d    = LOAD;
            mem_read_d = 1'b1;
            address_d  = {2'b00, req_addr[31:2]};
          end else if (req_size == 2'd2) begin
            state_d      = STORE;
            mem_write_d  = 1'b1;
            address_d    = {2'b00, req_addr[31:2]};
            write_data_d = req_wdata;
          end else begin
            state_d    = RMW_READ;
            mem_read_d = 1'b1;
            address_d  = {2'b00, req_addr[31:2]};
          end
        end
      end
      LOAD: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = write_q ? '0 : load_lane(ReadData, size_q, addr_q[1:0], unsigned_q);
      end
      STORE: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
      end
      // Merge is formed from the word read this cycle and written next cycle.
      RMW_READ: begin
        state_d      = RMW_WRITE;
        mem_write_d  = 1'b1;
        address_d    = address_q;
        write_data_d = merge_lane(ReadData, wdata_q, size_q, addr_q[1:0]);
      end
      RMW_WRITE: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
      end
      RESP: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      resp_rdata_q <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      address_q    <= '0;
      write_data_q <= '0;
      write_q      <= 1'b0;
      size_q       <= 2'd0;
      unsigned_q   <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_error_q <= resp_error_d;
      resp_rdata_q <= resp_rdata_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      address_q    <= address_d;
      write_data_q <= write_data_d;
      write_q      <= write_d;
      size_q       <= size_d;
      unsigned_q   <= unsigned_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  // Enables drop the moment reset rises so an in-flight store never lands.
  assign MemRead    = mem_read_q & ~reset;
  assign MemWrite   = mem_write_q & ~reset;
  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_error = resp_error_q;
  assign resp_rdata = resp_rdata_q;
  assign Address    = address_q;
  assign WriteData  = write_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a reference memory model predicts each
// response; a negedge monitor compares responses, latency and bus behaviour.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_error;
  logic [31:0] resp_rdata;
  logic        MemRead, MemWrite;
  logic [31:0] Address, WriteData, ReadData;

  load_store_unit #(.DATA_WIDTH(32), .MEMORY_DEPTH(1024)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_error(resp_error),
    .resp_rdata(resp_rdata), .MemRead(MemRead), .MemWrite(MemWrite),
    .Address(Address), .WriteData(WriteData), .ReadData(ReadData)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];
  assign ReadData = MemRead ? mem[Address[9:0]] : 32'h0;
  always @(posedge clk) if (MemWrite) mem[Address[9:0]] <= WriteData;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          acc;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference behaviour: byte-addressed little-endian memory, plain arithmetic.
  task automatic model(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d, input int acc);
    exp_t e;
    logic [31:0] idx, word, v, mask;
    int sh;
    idx     = a >> 2;
    e.acc   = acc;
    e.rdata = 32'h0;
    e.err   = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00)
           || (idx >= 32'd1024);
    if (e.err) begin
      e.lat = 1;
    end else if (!w) begin
      e.lat = 2;
      word  = ref_mem[idx];
      if (sz == 2'd0) begin
        v = (word >> (8 * a[1:0])) & 32'hFF;
        if (!u && v >= 32'd128) v = v | 32'hFFFF_FF00;
      end else if (sz == 2'd1) begin
        v = (word >> (16 * a[1])) & 32'hFFFF;
        if (!u && v >= 32'd32768) v = v | 32'hFFFF_0000;
      end else begin
        v = word;
      end
      e.rdata = v;
    end else if (sz == 2'd2) begin
      e.lat        = 2;
      ref_mem[idx] = d;
    end else begin
      e.lat        = 3;
      sh           = (sz == 2'd0) ? 8 * a[1:0] : 16 * a[1];
      mask         = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
      ref_mem[idx] = (ref_mem[idx] & ~mask) | ((d << sh) & mask);
    end
    sb.push_back(e);
  endtask

  // Returns #1 after the accepting edge, i.e. inside cycle 1 of the request.
  task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d,
                       input bit track, input bit keep);
    int budget;
    int acc;
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = d;
    budget = 0;
    while (!req_ready && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (!req_ready) begin
      chk("accept_timeout", req_ready, 1'b1);
      req_valid = 1'b0;
    end else begin
      acc = cyc;
      @(posedge clk);
      #1;
      if (track) model(w, sz, u, a, d, acc);
      req_valid    = keep;
      req_write    = 1'($urandom);
      req_size     = 2'($urandom);
      req_unsigned = 1'($urandom);
      req_addr     = $urandom;
      req_wdata    = $urandom;
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (MemRead || MemWrite) chk("rd_wr_exclusive", {31'h0, MemRead & MemWrite}, 32'h0);
      if (sb.size() > 0) begin
        chk("ready_while_busy", {31'h0, req_ready}, 32'h0);
        if (sb[0].err) chk("error_no_mem_access", {31'h0, MemRead | MemWrite}, 32'h0);
      end
      if (resp_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_resp", {31'h0, resp_valid}, 32'h0);
        end else begin
          mon_e = sb.pop_front();
          chk("resp_latency", cyc - mon_e.acc, mon_e.lat);
          chk("resp_error", {31'h0, resp_error}, {31'h0, mon_e.err});
          chk("resp_rdata", resp_rdata, mon_e.rdata);
        end
      end else if (sb.size() > 0 && (cyc - sb[0].acc) > sb[0].lat) begin
        chk("resp_missing", {31'h0, resp_valid}, 32'h1);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] v, a;
    logic [1:0]  sz;
    int          budget, mism;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    for (int i = 0; i < 1024; i++) begin
      v = $urandom;
      mem[i] <= v;
      ref_mem[i] = v;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset_memwrite", {31'h0, MemWrite}, 32'h0);
    chk("reset_memread", {31'h0, MemRead}, 32'h0);
    reset = 1'b0;
    chk("reset_ready", {31'h0, req_ready}, 32'h1);
    chk("reset_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("reset_resp_error", {31'h0, resp_error}, 32'h0);
    chk("reset_resp_rdata", resp_rdata, 32'h0);
    chk("reset_address", Address, 32'h0);
    chk("reset_writedata", WriteData, 32'h0);

    // Word store then word load at 0x10.
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b1, 1'b0);
    chk("wst_memwrite", {31'h0, MemWrite}, 32'h1);
    chk("wst_address", Address, 32'h4);
    chk("wst_writedata", WriteData, 32'hDEADBEEF);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0);
    chk("wld_memread", {31'h0, MemRead}, 32'h1);

    // Byte store 0xAA at 0x11 over 0x11223344, then signed/unsigned byte loads.
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, 1'b1, 1'b0);
    issue(1'b1, 2'd0, 1'b0, 32'h11, 32'h555555AA, 1'b1, 1'b0);
    chk("rmw_read_memread", {31'h0, MemRead}, 32'h1);
    @(posedge clk); #1;
    chk("rmw_write_memwrite", {31'h0, MemWrite}, 32'h1);
    chk("rmw_write_data", WriteData, 32'h1122AA44);
    issue(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 1'b1, 1'b0);
    issue(1'b0, 2'd0, 1'b1, 32'h11, 32'h0, 1'b1, 1'b0);

    // Half loads: signed upper half, then a misaligned half.
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h80017FFF, 1'b1, 1'b0);
    issue(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 1'b1, 1'b0);
    issue(1'b0, 2'd1, 1'b0, 32'h13, 32'h0, 1'b1, 1'b0);
    chk("herr_resp_cycle1", {31'h0, resp_valid}, 32'h1);
    chk("herr_memread", {31'h0, MemRead}, 32'h0);

    // Out-of-range word load.
    issue(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 1'b1, 1'b0);
    chk("range_memread", {31'h0, MemRead}, 32'h0);

    // Reset during the STORE cycle: write suppressed, request dropped.
    issue(1'b1, 2'd2, 1'b0, 32'h20, 32'hCAFEF00D, 1'b0, 1'b0);
    chk("midrst_store_active", {31'h0, MemWrite}, 32'h1);
    reset = 1'b1;
    #1;
    chk("midrst_memwrite_gated", {31'h0, MemWrite}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_ready", {31'h0, req_ready}, 32'h1);
    chk("midrst_mem_unchanged", mem[8], ref_mem[8]);
    repeat (3) @(negedge clk);
    chk("midrst_no_resp", {31'h0, resp_valid}, 32'h0);

    // Back-to-back loads with req_valid held high.
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1);
    issue(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 1'b1, 1'b1);
    issue(1'b0, 2'd2, 1'b0, 32'h18, 32'h0, 1'b1, 1'b0);

    // Randomized traffic over a small window to force lane/word collisions.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) == 0) a = $urandom | 32'h0000_1000;
      else a = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      sz = ($urandom_range(0, 9) == 9) ? 2'd3 : 2'($urandom_range(0, 2));
      issue(1'($urandom), sz, 1'($urandom), a, $urandom, 1'b1, 1'($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    req_valid = 1'b0;
    budget = 0;
    while (sb.size() != 0 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    @(negedge clk);
    chk("drain_pending", sb.size(), 32'h0);
    mism = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) mism++;
    chk("final_memory_mismatches", mism, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
